// File: rtl/pipelined_multibit_adder_pkg.sv
// Shared types and helpers for the pipelined multibit adder.
package pipelined_multibit_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Control part of a stage record; the operand/sum skew fields have
    // stage-dependent widths and live beside it in each stage.
    typedef struct packed {
        logic valid;
        logic carry;
        op_e  op;
    } stage_ctl_t;

    // Bits handled by each pipeline stage.
    function automatic int chunk_width(input int width, input int stages);
        if (stages < 1) begin
            return 0;
        end
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_multibit_adder_if.sv
// Operand-in / result-out handshake bundle for the pipelined adder.
interface pipelined_multibit_adder_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    // Operand producer / result consumer side.
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );

endinterface

// File: rtl/pipelined_multibit_adder_slice.sv
// Combinational W-bit adder chunk with carry out and carry into its MSB.
module pipelined_multibit_adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         cm
);

    // Chunk sum; the MSB carry-in is recovered from the MSB sum bit.
    always_comb begin
        {co, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        cm      = s[W-1] ^ x[W-1] ^ y[W-1];
    end

endmodule

// File: rtl/pipelined_multibit_adder.sv
// Pipelined add/subtract: WIDTH bits split into STAGES carry-chained chunks,
// one chunk per stage, with a single global advance enable for backpressure.
module pipelined_multibit_adder
    import pipelined_multibit_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic                      clk,
    input logic                      rst,
    pipelined_multibit_adder_if.slave bus
);

    localparam int CHUNK   = chunk_width(WIDTH, STAGES);
    localparam int DIV_CHK = (STAGES < 1) ? 1 : STAGES;

    if ((STAGES < 1) || ((WIDTH % DIV_CHK) != 0)) begin : g_bad_cfg
        $error("pipelined_multibit_adder: STAGES must be >= 1 and divide WIDTH");
    end

    logic             adv;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;

    // Whole pipeline moves together whenever the output slot frees up.
    assign adv           = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W = WIDTH - k * CHUNK;
        localparam int LO_W = (k + 1) * CHUNK;

        logic [IN_W-1:0]  a_in;
        logic [IN_W-1:0]  b_in;
        logic             v_in;
        logic             ci_in;
        op_e              op_in;
        logic [CHUNK-1:0] y;
        logic [CHUNK-1:0] s;
        logic             co;
        logic [LO_W-1:0]  sum_new;

        if (k == 0) begin : g_src
            assign a_in    = bus.a;
            assign b_in    = bus.b;
            assign v_in    = bus.in_valid;
            assign op_in   = op_e'(bus.sub);
            assign ci_in   = bus.c_in ^ bus.sub;
            assign sum_new = s;
        end else begin : g_src
            assign a_in    = g_stage[k-1].g_skew.a_hi;
            assign b_in    = g_stage[k-1].g_skew.b_hi;
            assign v_in    = g_stage[k-1].g_skew.ctl.valid;
            assign op_in   = g_stage[k-1].g_skew.ctl.op;
            assign ci_in   = g_stage[k-1].g_skew.ctl.carry;
            assign sum_new = {s, g_stage[k-1].g_skew.sum_lo};
        end

        // b is inverted chunk by chunk, so the raw operand rides the skew regs.
        assign y = b_in[CHUNK-1:0] ^ {CHUNK{op_in == OP_SUB}};

        if (k < STAGES - 1) begin : g_skew
            logic [IN_W-CHUNK-1:0] a_hi;
            logic [IN_W-CHUNK-1:0] b_hi;
            logic [LO_W-1:0]       sum_lo;
            stage_ctl_t            ctl;
            logic                  cm_unused;

            pipelined_multibit_adder_slice #(
                .W (CHUNK)
            ) u_slice (
                .x  (a_in[CHUNK-1:0]),
                .y  (y),
                .ci (ci_in),
                .s  (s),
                .co (co),
                .cm (cm_unused)
            );

            // Stage record: shifts on advance, holds on stall, cleared by reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ctl    <= '0;
                    a_hi   <= '0;
                    b_hi   <= '0;
                    sum_lo <= '0;
                end else if (adv) begin
                    ctl.valid <= v_in;
                    ctl.carry <= co;
                    ctl.op    <= op_in;
                    a_hi      <= a_in[IN_W-1:CHUNK];
                    b_hi      <= b_in[IN_W-1:CHUNK];
                    sum_lo    <= sum_new;
                end
            end
        end else begin : g_out
            logic cm;

            pipelined_multibit_adder_slice #(
                .W (CHUNK)
            ) u_slice (
                .x  (a_in[CHUNK-1:0]),
                .y  (y),
                .ci (ci_in),
                .s  (s),
                .co (co),
                .cm (cm)
            );

            // Output register: final chunk completes the sum and flags.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    c_out_q     <= 1'b0;
                    ovf_q       <= 1'b0;
                end else if (adv) begin
                    out_valid_q <= v_in;
                    sum_q       <= sum_new;
                    c_out_q     <= co;
                    ovf_q       <= cm ^ co;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_multibit_adder.sv
// Directed scoreboard bench for pipelined_multibit_adder (WIDTH=16, STAGES=4).
module tb_pipelined_multibit_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    typedef struct packed {
        logic        c;
        logic        v;
        logic [15:0] s;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipelined_multibit_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_multibit_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    res_t sb_q[$];
    int   tests   = 0;
    int   failed  = 0;
    int   run_len = 0;
    int   max_run = 0;
    res_t mon_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic sb);
        logic [15:0] be;
        logic [16:0] full;
        res_t        r;
        be   = sb ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {16'd0, ci ^ sb};
        r.s  = full[15:0];
        r.c  = full[16];
        r.v  = (a[15] == be[15]) && (full[15] != a[15]);
        return r;
    endfunction

    // Results are checked in order whenever the DUT hands one off.
    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
        end else if (bus.out_valid && bus.out_ready) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_exp = sb_q.pop_front();
                chk("result", 32'({bus.c_out, bus.ovf, bus.sum}), 32'(mon_exp));
            end
        end else begin
            run_len = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.c_in     = 1'($urandom);
        bus.sub      = 1'($urandom);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sb, input res_t exp, output int waited);
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = ci;
        bus.sub      = sb;
        bus.in_valid = 1'b1;
        waited       = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        else sb_q.push_back(exp);
        tick();
    endtask

    task automatic sendm(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sb);
        int w;
        send(a, b, ci, sb, model(a, b, ci, sb), w);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic latency_check(input string tag);
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk(tag, 32'(lat), 32'(STAGES));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          seen;
        logic [17:0] held;
        res_t        e;

        bus.out_ready = 1'b1;
        idle();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum",       32'(bus.sum),       32'd0);
        chk("rst_c_out",     32'(bus.c_out),     32'd0);
        chk("rst_ovf",       32'(bus.ovf),       32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        rst = 1'b0;
        tick();

        // Cross-chunk carry plus latency.
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, '{c: 1'b0, v: 1'b0, s: 16'h0100}, w);
        idle();
        latency_check("latency_first");
        drain();

        // Full wrap and signed overflow.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{c: 1'b1, v: 1'b0, s: 16'h0000}, w);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{c: 1'b0, v: 1'b1, s: 16'h8000}, w);
        idle();
        drain();

        // Subtract, with borrow-in on the second.
        send(16'h8000, 16'h0001, 1'b0, 1'b1, '{c: 1'b1, v: 1'b1, s: 16'h7FFF}, w);
        send(16'h0003, 16'h0005, 1'b1, 1'b1, '{c: 1'b0, v: 1'b0, s: 16'hFFFD}, w);
        idle();
        drain();

        // Streaming: 16 back-to-back operands.
        max_run = 0;
        for (int i = 0; i < 16; i++) begin
            e = '{c: 1'b0, v: 1'b0, s: 16'(2 * i + 1 + (i % 2))};
            send(16'(i), 16'(i + 1), 1'(i % 2), 1'b0, e, w);
            chk("stream_in_ready", 32'(w), 32'd0);
        end
        idle();
        drain();
        chk("stream_run", 32'(max_run), 32'd16);

        // Backpressure with a full pipeline and a waiting operand.
        bus.out_ready = 1'b0;
        sendm(16'h1234, 16'h4321, 1'b0, 1'b0);
        sendm(16'hF000, 16'h1000, 1'b1, 1'b0);
        sendm(16'h0001, 16'h0002, 1'b0, 1'b1);
        sendm(16'h8000, 16'h8000, 1'b0, 1'b0);
        bus.a        = 16'h00AA;
        bus.b        = 16'h0055;
        bus.c_in     = 1'b1;
        bus.sub      = 1'b1;
        bus.in_valid = 1'b1;
        held = {bus.c_out, bus.ovf, bus.sum};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_stable",    32'({bus.c_out, bus.ovf, bus.sum}), 32'(held));
            tick();
        end
        bus.out_ready = 1'b1;
        sendm(16'h00AA, 16'h0055, 1'b1, 1'b1);
        idle();
        drain();

        // Reset with two operands in flight.
        sendm(16'h1111, 16'h2222, 1'b0, 1'b0);
        sendm(16'h3333, 16'h4444, 1'b1, 1'b0);
        idle();
        rst = 1'b1;
        sb_q.delete();
        tick();
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_sum",       32'(bus.sum),       32'd0);
        chk("mid_rst_c_out",     32'(bus.c_out),     32'd0);
        chk("mid_rst_ovf",       32'(bus.ovf),       32'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
            tick();
        end
        chk("flushed_absent", 32'(seen), 32'd0);
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, '{c: 1'b0, v: 1'b0, s: 16'h1000}, w);
        idle();
        latency_check("latency_post_rst");
        drain();

        repeat (4) tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
